// File: rtl/cjtag_pkg.sv
// rtl/cjtag_pkg.sv - shared types and constants for the cJTAG host sequencer
package cjtag_pkg;

    typedef enum logic [1:0] {
        OP_RESET_ESC = 2'd0,
        OP_ACTIVATE  = 2'd1,
        OP_SCAN      = 2'd2,
        OP_DESELECT  = 2'd3
    } cjtag_op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ESC_RISE,
        ST_ESC_TOGGLE,
        ST_ESC_FALL,
        ST_ACT_SHIFT,
        ST_SCAN_TDI,
        ST_SCAN_TMS,
        ST_SCAN_TDO,
        ST_RESP
    } cjtag_state_e;

    localparam logic [3:0] OAC = 4'hC;
    localparam logic [3:0] EC  = 4'h8;
    localparam logic [3:0] CP  = 4'h0;

    // Shifted out LSB first: OAC, then EC, then CP.
    localparam logic [11:0] ACT_SEQ = {CP, EC, OAC};

    localparam int CLK_DIV_DEF    = 4;
    localparam int ESC_RESET_DEF  = 10;
    localparam int ESC_SELECT_DEF = 6;
    localparam int ESC_DESEL_DEF  = 4;

endpackage

// File: rtl/cjtag_tick_gen.sv
// rtl/cjtag_tick_gen.sv - divider producing one tick every CLK_DIV clocks
module cjtag_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] cnt_q;
    logic         wrap;

    assign wrap   = (cnt_q == W'(CLK_DIV - 1));
    assign tick_o = wrap && !clr_i;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            cnt_q <= '0;
        end else if (clr_i || wrap) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/cjtag_host_seq.sv
// rtl/cjtag_host_seq.sv - host-side cJTAG sequencer: escapes, OScan1 activation, 3-slot scans
module cjtag_host_seq
    import cjtag_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int ESC_RESET  = ESC_RESET_DEF,
    parameter int ESC_SELECT = ESC_SELECT_DEF,
    parameter int ESC_DESEL  = ESC_DESEL_DEF
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic       cmd_tms_i,
    input  logic       cmd_tdi_i,
    output logic       rsp_valid_o,
    output logic       rsp_tdo_o,
    output logic       tckc_o,
    output logic       tmsc_o,
    output logic       tmsc_oen_o,
    input  logic       tmsc_i,
    output logic       busy_o
);

    localparam int CW = $clog2(ESC_RESET + 1);

    cjtag_state_e  state_q;
    cjtag_op_e     op_q;
    logic          tms_q;
    logic [CW-1:0] cnt_q;
    logic [11:0]   sr_q;
    logic          ph_q;
    logic          tckc_q;
    logic          tmsc_q;
    logic          oen_q;
    logic          rsp_valid_q;
    logic          rsp_tdo_q;
    logic          ready_q;
    logic          tick;
    logic          accept;
    logic [CW-1:0] esc_last;

    assign accept = cmd_valid_i && ready_q;

    cjtag_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .clr_i  (accept),
        .tick_o (tick)
    );

    always_comb begin
        esc_last = CW'(ESC_DESEL - 1);
        case (op_q)
            OP_RESET_ESC: esc_last = CW'(ESC_RESET - 1);
            OP_ACTIVATE:  esc_last = CW'(ESC_SELECT - 1);
            default:      esc_last = CW'(ESC_DESEL - 1);
        endcase
    end

    // ph_q selects which half of a TCKC period the next tick produces (0 = rise).
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_RESET_ESC;
            tms_q       <= 1'b0;
            cnt_q       <= '0;
            sr_q        <= '0;
            ph_q        <= 1'b0;
            tckc_q      <= 1'b0;
            tmsc_q      <= 1'b1;
            oen_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_tdo_q   <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_q      <= cjtag_op_e'(cmd_op_i);
                        tms_q     <= cmd_tms_i;
                        cnt_q     <= '0;
                        sr_q      <= ACT_SEQ;
                        ph_q      <= 1'b0;
                        rsp_tdo_q <= 1'b0;
                        ready_q   <= 1'b0;
                        if (cjtag_op_e'(cmd_op_i) == OP_SCAN) begin
                            tmsc_q  <= ~cmd_tdi_i;
                            state_q <= ST_SCAN_TDI;
                        end else begin
                            state_q <= ST_ESC_RISE;
                        end
                    end
                end
                ST_ESC_RISE: if (tick) begin
                    tckc_q  <= 1'b1;
                    state_q <= ST_ESC_TOGGLE;
                end
                ST_ESC_TOGGLE: if (tick) begin
                    tmsc_q <= ~tmsc_q;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == esc_last) begin
                        cnt_q   <= '0;
                        state_q <= ST_ESC_FALL;
                    end
                end
                ST_ESC_FALL: if (tick) begin
                    if (!ph_q) begin
                        tckc_q <= 1'b0;
                        ph_q   <= 1'b1;
                    end else begin
                        ph_q <= 1'b0;
                        // Activation presents its first bit here instead of idling at 1.
                        if (op_q == OP_ACTIVATE) begin
                            tmsc_q  <= sr_q[0];
                            state_q <= ST_ACT_SHIFT;
                        end else begin
                            tmsc_q      <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_ACT_SHIFT: if (tick) begin
                    if (!ph_q) begin
                        tckc_q <= 1'b1;
                        ph_q   <= 1'b1;
                    end else begin
                        tckc_q <= 1'b0;
                        ph_q   <= 1'b0;
                        sr_q   <= sr_q >> 1;
                        cnt_q  <= cnt_q + CW'(1);
                        if (cnt_q == CW'(11)) begin
                            tmsc_q      <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end else begin
                            tmsc_q <= sr_q[1];
                        end
                    end
                end
                ST_SCAN_TDI: if (tick) begin
                    if (!ph_q) begin
                        tckc_q <= 1'b1;
                        ph_q   <= 1'b1;
                    end else begin
                        tckc_q  <= 1'b0;
                        ph_q    <= 1'b0;
                        tmsc_q  <= tms_q;
                        state_q <= ST_SCAN_TMS;
                    end
                end
                ST_SCAN_TMS: if (tick) begin
                    if (!ph_q) begin
                        tckc_q <= 1'b1;
                        ph_q   <= 1'b1;
                    end else begin
                        tckc_q  <= 1'b0;
                        ph_q    <= 1'b0;
                        oen_q   <= 1'b1;
                        state_q <= ST_SCAN_TDO;
                    end
                end
                ST_SCAN_TDO: if (tick) begin
                    if (!ph_q) begin
                        tckc_q    <= 1'b1;
                        ph_q      <= 1'b1;
                        rsp_tdo_q <= tmsc_i;
                    end else begin
                        tckc_q      <= 1'b0;
                        ph_q        <= 1'b0;
                        oen_q       <= 1'b0;
                        tmsc_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign busy_o      = ~ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_tdo_o   = rsp_tdo_q;
    assign tckc_o      = tckc_q;
    assign tmsc_o      = tmsc_q;
    assign tmsc_oen_o  = oen_q;

endmodule

// File: tb/tb_cjtag_host_seq.sv
// tb/tb_cjtag_host_seq.sv - directed self-checking bench for cjtag_host_seq
module tb_cjtag_host_seq;

    logic       clk = 1'b0;
    logic       nrst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic       cmd_tms;
    logic       cmd_tdi;
    logic       tdo_drv;
    logic       cmd_ready, rsp_valid, rsp_tdo, tckc, tmsc, tmsc_oen, busy;
    wire        tmsc_pad = tmsc_oen ? tdo_drv : tmsc;

    always #5 clk = ~clk;

    cjtag_host_seq #(.CLK_DIV(4), .ESC_RESET(10), .ESC_SELECT(6), .ESC_DESEL(4)) dut (
        .clk_i       (clk),
        .nrst_i      (nrst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_tms_i   (cmd_tms),
        .cmd_tdi_i   (cmd_tdi),
        .rsp_valid_o (rsp_valid),
        .rsp_tdo_o   (rsp_tdo),
        .tckc_o      (tckc),
        .tmsc_o      (tmsc),
        .tmsc_oen_o  (tmsc_oen),
        .tmsc_i      (tmsc_pad),
        .busy_o      (busy)
    );

    int checks = 0;
    int errors = 0;

    int          tog_hi = 0, rises = 0, oen_cyc = 0, oen_rises = 0, rsp_cnt = 0;
    logic [15:0] rise_bits = '0;
    logic        prev_tckc = 1'b0, prev_tmsc = 1'b1;

    // Pin monitor: TMSC changes with TCKC high on both sides, rises, slot3 windows.
    always @(negedge clk) begin
        if (tckc && !prev_tckc) begin
            rises++;
            rise_bits = {tmsc, rise_bits[15:1]};
            if (tmsc_oen) oen_rises++;
        end
        if (tckc && prev_tckc && (tmsc !== prev_tmsc)) tog_hi++;
        if (tmsc_oen) oen_cyc++;
        if (rsp_valid) rsp_cnt++;
        prev_tckc = tckc;
        prev_tmsc = tmsc;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        tog_hi = 0; rises = 0; oen_cyc = 0; oen_rises = 0; rise_bits = '0;
    endtask

    task automatic send(input logic [1:0] op, input logic tms, input logic tdi,
                        output logic tdo, output int cyc);
        @(negedge clk);
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_tms = tms; cmd_tdi = tdi; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
        end
        tdo = rsp_tdo;
        @(posedge clk); #1;
        if (cyc >= 400) chk("rsp_timeout", 32'd1, 32'd0);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    logic [31:0] idcode = 32'h1DEAD3FF;
    logic [31:0] word;
    logic        tdo;
    int          cyc, tot, base, acc;
    int          acc_t[4];
    int          viol;

    initial begin
        nrst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_tms = 1'b0; cmd_tdi = 1'b0; tdo_drv = 1'b0;

        // T1: reset values and a quiet idle line
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tckc", {31'd0, tckc}, 32'd0);
        chk("rst_tmsc", {31'd0, tmsc}, 32'd1);
        chk("rst_oen", {31'd0, tmsc_oen}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp", {30'd0, rsp_valid, rsp_tdo}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        nrst = 1'b1;
        clr_mon();
        repeat (20) @(posedge clk);
        #1;
        chk("idle_no_tckc", rises, 0);

        // T2: reset escape then activation
        clr_mon();
        send(2'd0, 1'b0, 1'b0, tdo, cyc);
        chk("reset_esc_toggles", tog_hi, 10);
        chk("reset_esc_latency", cyc, 4 * 13);
        chk("reset_esc_end_tmsc", {31'd0, tmsc}, 32'd1);
        chk("reset_esc_tdo", {31'd0, tdo}, 32'd0);
        clr_mon();
        send(2'd1, 1'b0, 1'b0, tdo, cyc);
        chk("act_toggles", tog_hi, 6);
        chk("act_latency", cyc, 4 * (6 + 3 + 24));
        chk("act_rises", rises, 13);
        chk("act_bits", {20'd0, rise_bits[15:4]}, 32'h08C);
        chk("act_end_tmsc", {31'd0, tmsc}, 32'd1);

        // T3: slot contents, then an IDCODE read-back through slot3
        clr_mon();
        send(2'd2, 1'b0, 1'b1, tdo, cyc);
        chk("scan_slots_tdi1_tms0", {30'd0, rise_bits[14:13]}, 32'd0);
        chk("scan_latency", cyc, 24);
        chk("scan_rises", rises, 3);
        chk("scan_no_toggle_hi", tog_hi, 0);
        clr_mon();
        send(2'd2, 1'b1, 1'b0, tdo, cyc);
        chk("scan_slots_tdi0_tms1", {30'd0, rise_bits[14:13]}, 32'd3);
        chk("scan_oen_cycles", oen_cyc, 8);
        chk("scan_oen_rises", oen_rises, 1);
        clr_mon();
        word = '0; tot = 0;
        for (int i = 0; i < 32; i++) begin
            tdo_drv = idcode[i];
            send(2'd2, (i == 31), 1'b0, tdo, cyc);
            word[i] = tdo;
            tot += cyc;
        end
        chk("idcode_stream", word, 32'h1DEAD3FF);
        chk("idcode_total_cycles", tot, 32 * 24);
        chk("idcode_oen_cycles", oen_cyc, 32 * 8);
        chk("idcode_oen_rises", oen_rises, 32);

        // T4: back-to-back SCANs with cmd_valid held high
        @(negedge clk);
        base = rsp_cnt; acc = 0; viol = 0;
        cmd_op = 2'd2; cmd_tms = 1'b0; cmd_tdi = 1'b1; cmd_valid = 1'b1;
        for (int c = 0; c < 300 && (acc < 4 || rsp_cnt - base < 4); c++) begin
            if (c > 0) @(negedge clk);
            if (busy && cmd_ready) viol++;
            if (cmd_valid && cmd_ready) begin
                acc_t[acc] = c;
                acc++;
            end else if (acc == 4) begin
                cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_ready_vs_busy", viol, 0);
        chk("b2b_accepts", acc, 4);
        chk("b2b_spacing", acc_t[1] - acc_t[0], 6 * 4 + 2);
        chk("b2b_spacing_3", acc_t[3] - acc_t[0], 3 * 26);
        chk("b2b_rsp_pulses", rsp_cnt - base, 4);

        // T5: reset mid-slot2 of a SCAN
        @(negedge clk);
        cmd_op = 2'd2; cmd_tms = 1'b0; cmd_tdi = 1'b0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (13) @(posedge clk);
        #2;
        chk("mid_slot2_tckc_high", {31'd0, tckc}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("async_rst_tckc", {31'd0, tckc}, 32'd0);
        chk("async_rst_tmsc", {31'd0, tmsc}, 32'd1);
        chk("async_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        base = rsp_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("dropped_no_rsp", rsp_cnt - base, 0);
        clr_mon();
        send(2'd0, 1'b0, 1'b0, tdo, cyc);
        chk("reesc_toggles", tog_hi, 10);
        clr_mon();
        send(2'd1, 1'b0, 1'b0, tdo, cyc);
        chk("react_latency", cyc, 4 * 33);
        chk("react_bits", {20'd0, rise_bits[15:4]}, 32'h08C);

        // T6: deselection escape, then a SCAN with the pad idle low
        clr_mon();
        send(2'd3, 1'b0, 1'b0, tdo, cyc);
        chk("desel_toggles", tog_hi, 4);
        chk("desel_latency", cyc, 4 * 7);
        tdo_drv = 1'b0;
        send(2'd2, 1'b0, 1'b1, tdo, cyc);
        chk("post_desel_tdo", {31'd0, tdo}, 32'd0);
        tdo_drv = 1'b1;
        send(2'd2, 1'b0, 1'b1, tdo, cyc);
        chk("tdo_sample_high", {31'd0, tdo}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
